// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32 control FSM with a bounded wait on memory handshakes.
// Define MC_CTRL_BRANCH_EXT_EN to accept bne/blt/bge in addition to beq.
module mc_controller #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Neg,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       Illegal,
  output logic       MemTimeout,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMREAD = 4'd3,
    MEMWB    = 4'd4,  MEMWRITE = 4'd5, EXECR  = 4'd6,  EXECI   = 4'd7,
    ALUWB    = 4'd8,  BRANCH  = 4'd9,  JALRADR = 4'd10, LINK   = 4'd11,
    JUMP     = 4'd12, LUI     = 4'd13
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t     state_r;
  state_t     next_s;
  state_t     dispatch_s;
  logic [7:0] cnt_r;
  logic       mem_wait_s, timeout_s, is_store_s;
  logic       bad_op_s, alu_f3_ok_s, br_f3_ok_s, br_taken_s;
  logic [2:0] alu_op_s;
  logic       pc_write_s, ir_write_s, reg_write_s, mem_read_s, mem_write_s, illegal_s;

  assign is_store_s = (Op == OP_STORE);
  assign mem_wait_s = (state_r == FETCH) || (state_r == MEMREAD) || (state_r == MEMWRITE);
  // A late MemReady on the limit cycle still completes normally.
  assign timeout_s  = mem_wait_s && !MemReady && (cnt_r == WAIT_LIM);

  // ALU operation select and legality of R/I funct3
  always_comb begin
    alu_f3_ok_s = 1'b1;
    alu_op_s    = 3'b000;
    case (funct3)
      3'b000:  alu_op_s = ((Op == OP_R) && funct7b5) ? 3'b001 : 3'b000;
      3'b111:  alu_op_s = 3'b010;
      3'b110:  alu_op_s = 3'b011;
      3'b100:  alu_op_s = 3'b100;
      3'b010:  alu_op_s = 3'b101;
      default: alu_f3_ok_s = 1'b0;
    endcase
  end

  // Branch condition and which branch kinds this build accepts
  always_comb begin
    br_taken_s = 1'b0;
    br_f3_ok_s = 1'b0;
    case (funct3)
      3'b000:  br_taken_s = Zero;
      3'b001:  br_taken_s = !Zero;
      3'b100:  br_taken_s = Neg;
      3'b101:  br_taken_s = !Neg;
      default: br_taken_s = 1'b0;
    endcase
`ifdef MC_CTRL_BRANCH_EXT_EN
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b101: br_f3_ok_s = 1'b1;
      default:                        br_f3_ok_s = 1'b0;
    endcase
`else
    br_f3_ok_s = (funct3 == 3'b000);
`endif
  end

  // Opcode dispatch out of DECODE
  always_comb begin
    dispatch_s = FETCH;
    bad_op_s   = 1'b0;
    case (Op)
      OP_LOAD, OP_STORE: dispatch_s = MEMADR;
      OP_R:    begin dispatch_s = EXECR;  bad_op_s = !alu_f3_ok_s; end
      OP_I:    begin dispatch_s = EXECI;  bad_op_s = !alu_f3_ok_s; end
      OP_BR:   begin dispatch_s = BRANCH; bad_op_s = !br_f3_ok_s;  end
      OP_JAL:  dispatch_s = LINK;
      OP_JALR: dispatch_s = JALRADR;
      OP_LUI:  dispatch_s = LUI;
      default: begin dispatch_s = FETCH; bad_op_s = 1'b1; end
    endcase
  end

  // Next-state selection
  always_comb begin
    next_s = FETCH;
    case (state_r)
      FETCH:        next_s = MemReady ? DECODE : FETCH;
      DECODE:       next_s = bad_op_s ? FETCH : dispatch_s;
      MEMADR:       next_s = is_store_s ? MEMWRITE : MEMREAD;
      MEMREAD:      next_s = MemReady ? MEMWB : (timeout_s ? FETCH : MEMREAD);
      MEMWRITE:     next_s = (MemReady || timeout_s) ? FETCH : MEMWRITE;
      EXECR, EXECI: next_s = ALUWB;
      JALRADR:      next_s = LINK;
      LINK:         next_s = JUMP;
      default:      next_s = FETCH;
    endcase
  end

  // State register and memory wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FETCH;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= next_s;
      if (mem_wait_s && !MemReady && !timeout_s) cnt_r <= cnt_r + 8'd1;
      else                                        cnt_r <= 8'd0;
    end
  end

  // Per-state datapath controls
  always_comb begin
    pc_write_s  = 1'b0;  ir_write_s  = 1'b0;  reg_write_s = 1'b0;
    mem_read_s  = 1'b0;  mem_write_s = 1'b0;  illegal_s   = 1'b0;
    AdrSrc      = 1'b0;  ResultSrc   = 2'b00; ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00; ALUControl  = 3'b000; ImmSrc     = 3'b000;
    case (state_r)
      FETCH: begin
        mem_read_s = !timeout_s;
        ALUSrcB    = 2'b10;
        ir_write_s = MemReady;
        pc_write_s = MemReady;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b01;
        ImmSrc    = (Op == OP_JAL) ? 3'b011 : 3'b010;
        illegal_s = bad_op_s;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = is_store_s ? 3'b001 : 3'b000;
      end
      MEMREAD:  begin AdrSrc = 1'b1; mem_read_s  = !timeout_s; end
      MEMWB:    begin ResultSrc = 2'b01; reg_write_s = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; mem_write_s = !timeout_s; end
      EXECR:    begin ALUSrcA = 2'b10; ALUControl = alu_op_s; end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_op_s;
      end
      ALUWB:    reg_write_s = 1'b1;
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        pc_write_s = br_taken_s;
      end
      JALRADR:  begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      LINK:     begin ResultSrc = 2'b10; reg_write_s = 1'b1; end
      JUMP:     pc_write_s = 1'b1;
      LUI:      begin ImmSrc = 3'b100; ResultSrc = 2'b11; reg_write_s = 1'b1; end
      default:  pc_write_s = 1'b0;
    endcase
  end

  assign PCWrite    = rst_n & pc_write_s;
  assign IRWrite    = rst_n & ir_write_s;
  assign RegWrite   = rst_n & reg_write_s;
  assign MemRead    = rst_n & mem_read_s;
  assign MemWrite   = rst_n & mem_write_s;
  assign Illegal    = rst_n & illegal_s;
  assign MemTimeout = rst_n & timeout_s;
  assign State      = state_r;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: an instruction-level model pushes the expected
// per-cycle control word; a negedge monitor pops and compares against the DUT.
module tb_mc_controller;
  localparam int WAIT_MAX = 15;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUIO = 7'b0110111;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic funct7b5, Zero, Neg, MemReady;
  logic PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AdrSrc, Illegal, MemTimeout;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] State;

  mc_controller #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .Illegal(Illegal), .MemTimeout(MemTimeout), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, irw, rw, mr, mw, adr;
    logic [1:0] res, sa, sb;
    logic [2:0] alu, imm;
    logic ill, tmo;
  } out_t;

  out_t  exp_q[$];
  string name_q[$];
  int checks = 0;
  int passed = 0;

  always @(negedge clk) begin
    out_t act, e;
    string nm;
    act = {State, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, MemTimeout};
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (act === e) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, e, $time);
    end
  end

  function automatic out_t mk(input logic [3:0] st);
    out_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic [2:0] alu_exp(input logic [2:0] f3, input bit sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b100:  return 3'b100;
      3'b010:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  task automatic cycle(input out_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    Zero     = 1'($urandom);
    Neg      = 1'($urandom);
    MemReady = 1'($urandom);
  endtask

  // One memory handshake: waits until ready or until WAIT_MAX stall cycles elapse.
  // pct < 0 means ready arrives exactly on the limit cycle.
  task automatic mem_phase(input logic [3:0] st, input int pct, output bit done);
    out_t e;
    done = 1'b0;
    for (int k = 0; k <= WAIT_MAX; k++) begin
      drive_rand();
      MemReady = (pct < 0) ? (k == WAIT_MAX) : (int'($urandom_range(99)) < pct);
      e = mk(st);
      e.adr = (st != 4'd0);
      if (st == 4'd0) e.sb = 2'b10;
      if (MemReady) begin
        if (st == 4'd0) begin e.irw = 1'b1; e.pcw = 1'b1; end
        e.mr = (st != 4'd5);
        e.mw = (st == 4'd5);
        cycle(e, "mem_done");
        done = 1'b1;
        return;
      end else if (k == WAIT_MAX) begin
        e.tmo = 1'b1;
        cycle(e, "mem_timeout");
        return;
      end else begin
        e.mr = (st != 4'd5);
        e.mw = (st == 4'd5);
        cycle(e, "mem_wait");
      end
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int fpct, input int mpct, input bit rst_in_wb);
    out_t e;
    bit done, ld, st, r, i, br, jal, jalr, lui, alu_ok, br_ok, bad, taken;
    ld = (op == LW); st = (op == SW); r = (op == RT); i = (op == IT);
    br = (op == BR); jal = (op == JAL); jalr = (op == JALR); lui = (op == LUIO);
    alu_ok = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b100) || (f3 == 3'b010);
`ifdef MC_CTRL_BRANCH_EXT_EN
    br_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
`else
    br_ok = (f3 == 3'b000);
`endif
    bad = !(ld || st || r || i || br || jal || jalr || lui) || ((r || i) && !alu_ok) || (br && !br_ok);

    Op = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
    mem_phase(4'd0, fpct, done);
    if (!done) return;
    Op = op; funct3 = f3; funct7b5 = f7;

    drive_rand();
    e = mk(4'd1); e.sa = 2'b01; e.sb = 2'b01;
    e.imm = jal ? 3'b011 : 3'b010;
    e.ill = bad;
    cycle(e, "decode");
    if (bad) return;

    if (ld || st) begin
      drive_rand();
      e = mk(4'd2); e.sa = 2'b10; e.sb = 2'b01; e.imm = st ? 3'b001 : 3'b000;
      cycle(e, "memadr");
      mem_phase(ld ? 4'd3 : 4'd5, mpct, done);
      if (done && ld) begin
        drive_rand();
        e = mk(4'd4); e.res = 2'b01; e.rw = !rst_in_wb;
        if (rst_in_wb) rst_n = 1'b0;
        cycle(e, "memwb");
        if (rst_in_wb) begin
          drive_rand();
          e = mk(4'd0); e.sb = 2'b10;
          cycle(e, "reset_hold");
          rst_n = 1'b1;
        end
      end
    end else if (r || i) begin
      drive_rand();
      e = mk(r ? 4'd6 : 4'd7); e.sa = 2'b10; e.sb = r ? 2'b00 : 2'b01;
      e.alu = alu_exp(f3, r && f7);
      cycle(e, "exec");
      drive_rand();
      e = mk(4'd8); e.rw = 1'b1;
      cycle(e, "aluwb");
    end else if (br) begin
      drive_rand();
      case (f3)
        3'b000:  taken = Zero;
        3'b001:  taken = !Zero;
        3'b100:  taken = Neg;
        3'b101:  taken = !Neg;
        default: taken = 1'b0;
      endcase
      e = mk(4'd9); e.sa = 2'b10; e.alu = 3'b001; e.pcw = taken;
      cycle(e, "branch");
    end else if (lui) begin
      drive_rand();
      e = mk(4'd13); e.imm = 3'b100; e.res = 2'b11; e.rw = 1'b1;
      cycle(e, "lui");
    end else begin
      if (jalr) begin
        drive_rand();
        e = mk(4'd10); e.sa = 2'b10; e.sb = 2'b01;
        cycle(e, "jalradr");
      end
      drive_rand();
      e = mk(4'd11); e.res = 2'b10; e.rw = 1'b1;
      cycle(e, "link");
      drive_rand();
      e = mk(4'd12); e.pcw = 1'b1;
      cycle(e, "jump");
    end
  endtask

  initial begin
    out_t e;
    logic [6:0] ops [8];
    logic [6:0] op;
    int mp;
    ops = '{LW, SW, RT, IT, BR, JAL, JALR, LUIO};
    rst_n = 1'b0; Op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    Zero = 1'b0; Neg = 1'b0; MemReady = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) begin
      drive_rand();
      e = mk(4'd0); e.sb = 2'b10;
      cycle(e, "reset");
    end
    rst_n = 1'b1;

    run_instr(LW,   3'b010, 1'b0, 100, 100, 1'b0);
    run_instr(RT,   3'b000, 1'b1, 100, 100, 1'b0);
    run_instr(IT,   3'b000, 1'b1, 100, 100, 1'b0);
    run_instr(RT,   3'b010, 1'b0, 100, 100, 1'b0);
    run_instr(BR,   3'b000, 1'b0, 100, 100, 1'b0);
    run_instr(BR,   3'b000, 1'b0, 100, 100, 1'b0);
    run_instr(BR,   3'b001, 1'b0, 100, 100, 1'b0);
    run_instr(BR,   3'b101, 1'b0, 100, 100, 1'b0);
    run_instr(JAL,  3'b000, 1'b0, 100, 100, 1'b0);
    run_instr(JALR, 3'b000, 1'b0, 100, 100, 1'b0);
    run_instr(LUIO, 3'b000, 1'b0, 100, 100, 1'b0);
    run_instr(SW,   3'b010, 1'b0, 100, 0,   1'b0);
    run_instr(LW,   3'b010, 1'b0, 100, -1,  1'b0);
    run_instr(LW,   3'b010, 1'b0, 0,   100, 1'b0);
    run_instr(7'b1111111, 3'b000, 1'b0, 100, 100, 1'b0);
    run_instr(IT,   3'b001, 1'b0, 100, 100, 1'b0);
    run_instr(LW,   3'b010, 1'b0, 100, 100, 1'b1);

    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(9) == 0) ? 7'($urandom) : ops[$urandom_range(7)];
      case ($urandom_range(3))
        0:       mp = 100;
        1:       mp = 50;
        2:       mp = 0;
        default: mp = -1;
      endcase
      run_instr(op, 3'($urandom), 1'($urandom), ($urandom_range(9) == 0) ? 0 : 80, mp,
                ($urandom_range(7) == 0));
    end

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
